// File: rtl/desc_replay_tx.sv
// Two-pass descriptor transmitter: buffers one AXI-Stream descriptor, then replays it
// twice (tuser = pass index) for the L2-normalize stage.
module desc_replay_tx #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       desc_count,
    output logic [1:0]        dbg_state
);
    // Both ports: a beat transfers on a rising edge where tvalid && tready; the
    // master holds tdata/tlast/tuser stable and never drops tvalid before that edge.
    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] SEND0 = 2'd1;
    localparam logic [1:0] SEND1 = 2'd2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_BEATS - 1);

    logic [DATA_W-1:0] r_mem [MAX_BEATS];
    logic [1:0]        r_state;
    logic              r_live;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_full;
    logic [ADDR_W-1:0] r_len_m1;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_active;
    logic              r_rd_pass;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_v;
    logic              r_rd_last;
    logic              r_rd_user;
    logic [DATA_W-1:0] r_sk_data;
    logic              r_sk_v;
    logic              r_sk_last;
    logic              r_sk_user;
    logic              r_overflow;
    logic [15:0]       r_desc_count;

    logic w_s_hs;
    logic w_m_hs;
    logic w_ren;
    logic w_rd_end;
    logic w_keep_rd;
    logic w_keep_sk;

    assign s_axis_tready = r_live && (r_state == FILL);
    assign w_s_hs        = s_axis_tvalid && s_axis_tready;

    // Output presents the older of the two registered entries: skid first, then RAM read register.
    assign m_axis_tvalid = r_sk_v || r_rd_v;
    assign m_axis_tdata  = r_sk_v ? r_sk_data : r_rd_data;
    assign m_axis_tlast  = r_sk_v ? r_sk_last : r_rd_last;
    assign m_axis_tuser  = r_sk_v ? r_sk_user : r_rd_user;
    assign w_m_hs        = m_axis_tvalid && m_axis_tready;

    // A read is only launched while at least one entry is free, so tready never gates the RAM.
    assign w_ren     = r_rd_active && !(r_sk_v && r_rd_v);
    assign w_rd_end  = (r_rd_addr == r_len_m1);
    assign w_keep_rd = r_rd_v && !(w_m_hs && !r_sk_v);
    assign w_keep_sk = r_sk_v && !w_m_hs;

    assign busy       = (r_state != FILL);
    assign overflow   = r_overflow;
    assign desc_count = r_desc_count;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (w_s_hs && !r_wr_full) begin
            r_mem[r_wr_addr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= FILL;
            r_live       <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_full    <= 1'b0;
            r_len_m1     <= '0;
            r_rd_addr    <= '0;
            r_rd_active  <= 1'b0;
            r_rd_pass    <= 1'b0;
            r_rd_data    <= '0;
            r_rd_v       <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_user    <= 1'b0;
            r_sk_data    <= '0;
            r_sk_v       <= 1'b0;
            r_sk_last    <= 1'b0;
            r_sk_user    <= 1'b0;
            r_overflow   <= 1'b0;
            r_desc_count <= '0;
        end else begin
            r_live <= 1'b1;

            if (w_ren) begin
                r_rd_data <= r_mem[r_rd_addr];
                r_rd_last <= w_rd_end;
                r_rd_user <= r_rd_pass;
                r_rd_v    <= 1'b1;
                if (w_keep_rd) begin
                    r_sk_data <= r_rd_data;
                    r_sk_last <= r_rd_last;
                    r_sk_user <= r_rd_user;
                    r_sk_v    <= 1'b1;
                end else begin
                    r_sk_v <= w_keep_sk;
                end
                // Pass 1 reads follow pass 0 directly so the boundary has no bubble.
                if (w_rd_end) begin
                    r_rd_addr <= '0;
                    if (r_rd_pass) begin
                        r_rd_active <= 1'b0;
                    end else begin
                        r_rd_pass <= 1'b1;
                    end
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end else begin
                r_rd_v <= w_keep_rd;
                r_sk_v <= w_keep_sk;
            end

            if (w_m_hs && m_axis_tlast) begin
                if (r_state == SEND0) begin
                    r_state <= SEND1;
                end else if (r_state == SEND1) begin
                    r_state      <= FILL;
                    r_desc_count <= r_desc_count + 16'd1;
                end
            end

            if (w_s_hs) begin
                if (r_wr_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                    if (r_wr_addr == LAST_ADDR) begin
                        r_wr_full <= 1'b1;
                    end
                end
                if (s_axis_tlast) begin
                    r_len_m1    <= r_wr_full ? LAST_ADDR : r_wr_addr;
                    r_wr_addr   <= '0;
                    r_wr_full   <= 1'b0;
                    r_state     <= SEND0;
                    r_rd_active <= 1'b1;
                    r_rd_addr   <= '0;
                    r_rd_pass   <= 1'b0;
                end
            end
        end
    end
endmodule
